// File: rtl/pblaze_io_pkg.sv
// rtl/pblaze_io_pkg.sv - shared port addresses, limits and helpers for pacoblaze3 I/O peripherals
package pblaze_io_pkg;

    localparam logic [7:0] IRQ_STATUS_PORT = 8'h01;
    localparam logic [7:0] IRQ_ID_PORT     = 8'h02;
    localparam logic [7:0] IRQ_CLEAR_PORT  = 8'h04;
    localparam logic [7:0] IRQ_MASK_PORT   = 8'h08;

    localparam int MAX_IRQ_SRC = 8;

    // Request state doubles as the in_service flag.
    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_SERVICE = 1'b1
    } irq_state_t;

    // Returns {valid, id[2:0]}; the lowest set index wins, id is 0 when nothing is set.
    function automatic logic [3:0] irq_prio_enc(input logic [MAX_IRQ_SRC-1:0] active);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = MAX_IRQ_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pblaze_irq_ctrl_if.sv
// rtl/pblaze_irq_ctrl_if.sv - pacoblaze3 port bus and interrupt handshake
interface pblaze_irq_ctrl_if;

    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] rd_data;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        input  interrupt, rd_data
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        output interrupt, rd_data
    );

endinterface

// File: rtl/pblaze_tick_gen.sv
// rtl/pblaze_tick_gen.sv - free-running modulo-PERIOD counter with a 1-cycle wrap pulse
module pblaze_tick_gen #(
    parameter int PERIOD = 25000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pblaze_irq_ctrl.sv
// rtl/pblaze_irq_ctrl.sv - edge-triggered interrupt controller for pacoblaze3 (optional IRQ_TIMER_EN timer on source 0)
module pblaze_irq_ctrl
    import pblaze_io_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter logic [7:0] STATUS_PORT = IRQ_STATUS_PORT,
    parameter logic [7:0] ID_PORT     = IRQ_ID_PORT,
    parameter logic [7:0] MASK_PORT   = IRQ_MASK_PORT,
    parameter logic [7:0] CLEAR_PORT  = IRQ_CLEAR_PORT,
    parameter int         TICK_PERIOD = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    pblaze_irq_ctrl_if.slave   bus
);

    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_bits;
    logic [7:0]         active;
    logic [3:0]         prio;
    irq_state_t         state;
    logic               irq_q;
    logic [7:0]         rd_q;
    logic               wr_mask;
    logic               wr_clear;

    assign wr_mask  = bus.write_strobe && (bus.port_id == MASK_PORT);
    assign wr_clear = bus.write_strobe && (bus.port_id == CLEAR_PORT);

`ifdef IRQ_TIMER_EN
    logic tick;

    pblaze_tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        rise    = src & ~src_d;
        rise[0] = tick;
    end
`else
    assign rise = src & ~src_d;
`endif

    always_comb begin
        active              = 8'h00;
        active[NUM_SRC-1:0] = pending & mask;
        prio                = irq_prio_enc(active);
        clr_bits            = wr_clear ? bus.out_port[NUM_SRC-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_d   <= '0;
            pending <= '0;
            mask    <= '0;
            state   <= IRQ_IDLE;
            irq_q   <= 1'b0;
            rd_q    <= 8'h00;
        end else begin
            src_d   <= src;
            // Clear first, then OR in new edges so a same-cycle event survives.
            pending <= (pending & ~clr_bits) | rise;
            if (wr_mask) begin
                mask <= bus.out_port[NUM_SRC-1:0];
            end

            case (state)
                IRQ_IDLE: begin
                    if (bus.interrupt_ack) begin
                        irq_q <= 1'b0;
                        state <= IRQ_SERVICE;
                    end else if (|active) begin
                        irq_q <= 1'b1;
                    end
                end
                IRQ_SERVICE: begin
                    irq_q <= 1'b0;
                    if (wr_clear) begin
                        state <= IRQ_IDLE;
                    end
                end
                default: begin
                    irq_q <= 1'b0;
                    state <= IRQ_IDLE;
                end
            endcase

            if (bus.port_id == STATUS_PORT) begin
                rd_q <= active;
            end else if (bus.port_id == ID_PORT) begin
                rd_q <= {prio[3], 4'b0000, prio[2:0]};
            end else begin
                rd_q <= 8'h00;
            end
        end
    end

    assign bus.interrupt = irq_q;
    assign bus.rd_data   = rd_q;

    // Reads have no side effects and upper write-data bits are don't-care.
    wire unused_bus = &{1'b0, bus.read_strobe, bus.out_port};

endmodule

// File: tb/tb_pblaze_irq_ctrl.sv
// tb/tb_pblaze_irq_ctrl.sv - directed self-checking bench for pblaze_irq_ctrl
module tb_pblaze_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] src;
    int         errors;
    int         checks;
    int         cyc;

    pblaze_irq_ctrl_if bus ();

    pblaze_irq_ctrl #(
        .NUM_SRC     (4),
        .TICK_PERIOD (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        bus.port_id      = port;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
        bus.out_port     = 8'h00;
        bus.port_id      = 8'hFF;
    endtask

    task automatic rd(input logic [7:0] port, output logic [7:0] data);
        bus.port_id = port;
        step();
        data        = bus.rd_data;
        bus.port_id = 8'hFF;
    endtask

    task automatic ack();
        bus.interrupt_ack = 1'b1;
        step();
        bus.interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string tag, output int at);
        int n;
        n  = 0;
        at = -1;
        while (bus.interrupt !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bus.interrupt === 1'b1) begin
            at = cyc;
        end else begin
            chk(tag, 32'(bus.interrupt), 32'd1);
        end
    endtask

    logic [7:0] d;
    int t0, t1, t2;

    initial begin
        errors            = 0;
        checks            = 0;
        reset             = 1'b1;
        src               = 4'b0000;
        bus.port_id       = 8'hFF;
        bus.out_port      = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_irq", 32'(bus.interrupt), 32'd0);
        chk("reset_rd", 32'(bus.rd_data), 32'd0);

`ifdef IRQ_TIMER_EN
        wr(8'h08, 8'h01);
        wait_irq("tmr_first", t0);
        ack();
        src = 4'b0001;
        wr(8'h04, 8'h01);
        src = 4'b0000;
        wait_irq("tmr_second", t1);
        ack();
        src = 4'b0001;
        wr(8'h04, 8'h01);
        wait_irq("tmr_third", t2);
        src = 4'b0000;
        chk("tmr_period1", 32'(t1 - t0), 32'd10);
        chk("tmr_period2", 32'(t2 - t1), 32'd10);
`else
        // Masked source: pending but invisible.
        src = 4'b0100;
        step();
        src = 4'b0000;
        step();
        chk("masked_irq", 32'(bus.interrupt), 32'd0);
        rd(8'h01, d);
        chk("masked_status", 32'(d), 32'h00);

        wr(8'h08, 8'h04);
        step();
        chk("unmask_irq", 32'(bus.interrupt), 32'd1);
        rd(8'h02, d);
        chk("unmask_id", 32'(d), 32'h82);

        ack();
        chk("ack1_irq", 32'(bus.interrupt), 32'd0);
        wr(8'h04, 8'h04);
        step();
        chk("eoi_empty_irq", 32'(bus.interrupt), 32'd0);

        // Two simultaneous sources, lowest index wins.
        wr(8'h08, 8'h0F);
        src = 4'b1010;
        step();
        src = 4'b0000;
        step();
        chk("two_src_irq", 32'(bus.interrupt), 32'd1);
        rd(8'h02, d);
        chk("two_src_id", 32'(d), 32'h81);

        ack();
        chk("ack2_irq", 32'(bus.interrupt), 32'd0);
        wr(8'h04, 8'h02);
        step();
        chk("eoi_reassert", 32'(bus.interrupt), 32'd1);
        rd(8'h02, d);
        chk("eoi_id", 32'(d), 32'h83);

        // Ack in SERVICE is ignored; interrupt held low until EOI.
        ack();
        src               = 4'b0001;
        bus.interrupt_ack = 1'b1;
        step();
        src               = 4'b0000;
        bus.interrupt_ack = 1'b0;
        step();
        step();
        chk("service_hold", 32'(bus.interrupt), 32'd0);
        wr(8'h04, 8'h00);
        step();
        chk("eoi_zero_irq", 32'(bus.interrupt), 32'd1);
        rd(8'h02, d);
        chk("src0_id", 32'(d), 32'h80);

        // Same-cycle set and clear on bit 1: set wins.
        src              = 4'b0010;
        bus.port_id      = 8'h04;
        bus.out_port     = 8'h02;
        bus.write_strobe = 1'b1;
        step();
        src              = 4'b0000;
        bus.write_strobe = 1'b0;
        bus.out_port     = 8'h00;
        bus.port_id      = 8'hFF;
        rd(8'h01, d);
        chk("set_wins", 32'(d), 32'h0B);
        wr(8'h04, 8'h08);
        rd(8'h01, d);
        chk("clear_bit3", 32'(d), 32'h03);

        // Mask bits above NUM_SRC are dropped.
        wr(8'h08, 8'hF2);
        rd(8'h01, d);
        chk("mask_upper", 32'(d), 32'h02);
        rd(8'h02, d);
        chk("mask_upper_id", 32'(d), 32'h81);

        // Reset with interrupt asserted in IDLE.
        chk("pre_reset_irq", 32'(bus.interrupt), 32'd1);
        reset       = 1'b1;
        bus.port_id = 8'h01;
        step();
        reset       = 1'b0;
        bus.port_id = 8'hFF;
        chk("mid_reset_irq", 32'(bus.interrupt), 32'd0);
        chk("mid_reset_rd", 32'(bus.rd_data), 32'd0);
        src = 4'b0010;
        step();
        src = 4'b0000;
        step();
        rd(8'h01, d);
        chk("post_reset_mask", 32'(d), 32'h00);
        chk("post_reset_irq", 32'(bus.interrupt), 32'd0);

        wr(8'h08, 8'h0F);
        rd(8'h10, d);
        chk("unmapped", 32'(d), 32'h00);
        rd(8'h01, d);
        chk("status_after_remask", 32'(d), 32'h02);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
